// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: controller state encoding
// and the width of the optional stall counter.
// The stall counter is built only when SRAM_PORT_ARBITER_PERF_EN is defined.
package sram_arb_pkg;

   typedef enum logic {
      ARB_CLEAR = 1'b0,
      ARB_RUN   = 1'b1
   } arb_state_e;

   localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin picker. The search starts at rr_ptr_i and wraps from
// NUM_REQ-1 back to 0. It also returns the pointer value that follows the
// winner. With en_i low nothing is granted.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] rr_ptr_i,
   input  logic                en_i,
   output logic [NUM_REQ-1:0]  grant_o,
   output logic [ID_WIDTH-1:0] grant_id_o,
   output logic [ID_WIDTH-1:0] rr_ptr_d_o
);

   int                  idx;
   logic [ID_WIDTH-1:0] sel;
   logic                found;

   // Scan requesters in rotating priority order and keep the first hit.
   always_comb begin
      grant_o    = '0;
      grant_id_o = '0;
      rr_ptr_d_o = rr_ptr_i;
      found      = 1'b0;
      idx        = 0;
      sel        = '0;
      if (en_i) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = ID_WIDTH'(idx);
            if (!found && req_i[sel]) begin
               found        = 1'b1;
               grant_o[sel] = 1'b1;
               grant_id_o   = sel;
               rr_ptr_d_o   = (idx == NUM_REQ - 1) ? '0 : ID_WIDTH'(idx + 1);
            end
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1r1w SRAM between NUM_REQ round-robin readers and one writer.
// After every reset, the controller writes zero to every entry (CLEAR).
// Only then does it accept accesses (RUN).
// Read data comes straight from the SRAM one cycle after the grant, tagged
// with the requester id.
// Handshake: a requester holds rd_req/rd_addr until it sees rd_grant in the
// same cycle. Writes are accepted whenever wr_req is high in RUN, and wr_ack
// is wr_req. No ready/stall exists for writes.
// Optional: SRAM_PORT_ARBITER_PERF_EN adds the perf_stall_count output.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 20,
   parameter int SIZE       = 64,
   parameter int ADDR_WIDTH = $clog2(SIZE),
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            rd_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_REQ-1:0]            rd_grant,
   output logic                          rd_resp_valid,
   output logic [ID_WIDTH-1:0]           rd_resp_id,
   output logic [DATA_WIDTH-1:0]         rd_resp_data,
   input  logic                          wr_req,
   input  logic [ADDR_WIDTH-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          wr_ack,
   output logic                          init_done,
   output logic                          sram_read_en,
   output logic [ADDR_WIDTH-1:0]         sram_read_addr,
   input  logic [DATA_WIDTH-1:0]         sram_read_data,
   output logic                          sram_write_en,
   output logic [ADDR_WIDTH-1:0]         sram_write_addr,
   output logic [DATA_WIDTH-1:0]         sram_write_data,
   output arb_state_e                    dbg_state
`ifdef SRAM_PORT_ARBITER_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0]         perf_stall_count
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   arb_state_e          state_q;
   logic [ADDR_WIDTH-1:0] clear_ptr_q;
   logic [ID_WIDTH-1:0] rr_ptr_q;
   logic [ID_WIDTH-1:0] rr_ptr_d;
   logic [ID_WIDTH-1:0] grant_id;
   logic [NUM_REQ-1:0]  grant;
   logic                init_done_q;
   logic                resp_valid_q;
   logic [ID_WIDTH-1:0] resp_id_q;
   logic                run;

   assign run = (state_q == ARB_RUN);

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_arbiter (
      .req_i      (rd_req),
      .rr_ptr_i   (rr_ptr_q),
      .en_i       (run),
      .grant_o    (grant),
      .grant_id_o (grant_id),
      .rr_ptr_d_o (rr_ptr_d)
   );

   // Read port: the winner's address goes straight to the SRAM.
   assign rd_grant       = grant;
   assign sram_read_en   = |grant;
   assign sram_read_addr = sram_read_en ? rd_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH] : '0;

   // Write port: the clear sequencer owns it until RUN, then the writer does.
   assign sram_write_en   = run ? wr_req  : 1'b1;
   assign sram_write_addr = run ? wr_addr : clear_ptr_q;
   assign sram_write_data = run ? wr_data : '0;
   assign wr_ack          = run & wr_req;

   assign rd_resp_valid = resp_valid_q;
   assign rd_resp_id    = resp_id_q;
   assign rd_resp_data  = sram_read_data;
   assign init_done     = init_done_q;
   assign dbg_state     = state_q;

   // Clear/run controller, round-robin pointer and read response tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_CLEAR;
         clear_ptr_q  <= '0;
         rr_ptr_q     <= '0;
         init_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
      end else begin
         unique case (state_q)
            ARB_CLEAR: begin
               resp_valid_q <= 1'b0;
               if (clear_ptr_q == LAST_ADDR) begin
                  clear_ptr_q <= '0;
                  state_q     <= ARB_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  clear_ptr_q <= clear_ptr_q + 1'b1;
               end
            end
            ARB_RUN: begin
               resp_valid_q <= |grant;
               if (|grant) begin
                  resp_id_q <= grant_id;
                  rr_ptr_q  <= rr_ptr_d;
               end
            end
            default: state_q <= ARB_CLEAR;
         endcase
      end
   end

`ifdef SRAM_PORT_ARBITER_PERF_EN
   logic [PERF_CNT_W-1:0] perf_q;

   // Count RUN cycles where some requester was left waiting; saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= '0;
      end else if (run && ((rd_req & ~grant) != '0) && (perf_q != '1)) begin
         perf_q <= perf_q + 1'b1;
      end
   end

   assign perf_stall_count = perf_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter (SIZE=52, NUM_REQ=4, 20-bit data).
// Includes a NEW_DATA 1r1w SRAM model. Expected values come from a
// spec-level reference (memory array, rotating priority pointer, and a
// queue of expected responses).
// Define SRAM_PORT_ARBITER_PERF_EN to also check perf_stall_count.
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 20;
   localparam int SZ = 52;
   localparam int AW = $clog2(SZ);
   localparam int IW = $clog2(NR);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NR-1:0]    rd_req;
   logic [NR*AW-1:0] rd_addr;
   logic [NR-1:0]    rd_grant;
   logic             rd_resp_valid;
   logic [IW-1:0]    rd_resp_id;
   logic [DW-1:0]    rd_resp_data;
   logic             wr_req;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             wr_ack;
   logic             init_done;
   logic             sram_read_en;
   logic [AW-1:0]    sram_read_addr;
   logic [DW-1:0]    sram_read_data;
   logic             sram_write_en;
   logic [AW-1:0]    sram_write_addr;
   logic [DW-1:0]    sram_write_data;
   arb_state_e       dbg_state;
`ifdef SRAM_PORT_ARBITER_PERF_EN
   logic [31:0]      perf_stall_count;
`endif

   sram_port_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .SIZE       (SZ)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rd_req          (rd_req),
      .rd_addr         (rd_addr),
      .rd_grant        (rd_grant),
      .rd_resp_valid   (rd_resp_valid),
      .rd_resp_id      (rd_resp_id),
      .rd_resp_data    (rd_resp_data),
      .wr_req          (wr_req),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .wr_ack          (wr_ack),
      .init_done       (init_done),
      .sram_read_en    (sram_read_en),
      .sram_read_addr  (sram_read_addr),
      .sram_read_data  (sram_read_data),
      .sram_write_en   (sram_write_en),
      .sram_write_addr (sram_write_addr),
      .sram_write_data (sram_write_data),
      .dbg_state       (dbg_state)
`ifdef SRAM_PORT_ARBITER_PERF_EN
      ,
      .perf_stall_count(perf_stall_count)
`endif
   );

   // ---------------- SRAM model (NEW_DATA on same-address collision) ----------------
   logic [DW-1:0] mem [SZ];
   bit            fill_garbage = 1'b0;

   always @(posedge clk) begin
      if (fill_garbage) begin
         for (int i = 0; i < SZ; i++) mem[i] <= DW'($urandom);
      end else begin
         if (sram_read_en) begin
            if (sram_write_en && sram_write_addr == sram_read_addr)
               sram_read_data <= sram_write_data;
            else if (int'(sram_read_addr) < SZ)
               sram_read_data <= mem[sram_read_addr];
            else
               sram_read_data <= 'x;
         end
         if (sram_write_en && int'(sram_write_addr) < SZ)
            mem[sram_write_addr] <= sram_write_data;
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0]    model_mem [SZ];
   int               model_ptr;
   logic [31:0]      model_perf;
   logic [IW+DW-1:0] exp_q[$];
   int               last_g;
   logic [NR-1:0]    dut_grant_seen;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First asserted requester at or after ptr, wrapping around; -1 if none.
   function automatic int pick(input logic [NR-1:0] req, input int ptr);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (ptr + k) % NR;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, SZ - 1));
   endfunction

   // ---------------- driver tasks ----------------
   // One RUN cycle with the inputs already driven: checks, model update, advance.
   task automatic run_cycle();
      logic [IW+DW-1:0] e;
      logic [NR-1:0]    exp_grant;
      logic [AW-1:0]    a;
      logic [DW-1:0]    d;
      int               g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("resp_valid", 32'(rd_resp_valid), 32'd1);
         check("resp_id", 32'(rd_resp_id), 32'(e[DW +: IW]));
         check("resp_data", 32'(rd_resp_data), 32'(e[DW-1:0]));
      end else begin
         check("resp_valid_idle", 32'(rd_resp_valid), 32'd0);
      end
      g = pick(rd_req, model_ptr);
      exp_grant = (g >= 0) ? NR'(1 << g) : '0;
      dut_grant_seen = rd_grant;
      check("rd_grant", 32'(rd_grant), 32'(exp_grant));
      check("sram_read_en", 32'(sram_read_en), (g >= 0) ? 32'd1 : 32'd0);
      if (g >= 0) check("sram_read_addr", 32'(sram_read_addr), 32'(rd_addr[g*AW +: AW]));
      check("wr_ack", 32'(wr_ack), 32'(wr_req));
      check("sram_write_en", 32'(sram_write_en), 32'(wr_req));
      if (wr_req) begin
         check("sram_write_addr", 32'(sram_write_addr), 32'(wr_addr));
         check("sram_write_data", 32'(sram_write_data), 32'(wr_data));
      end
      check("run_init_done", 32'(init_done), 32'd1);
      check("run_state", 32'(dbg_state), 32'(ARB_RUN));
`ifdef SRAM_PORT_ARBITER_PERF_EN
      check("perf_count", perf_stall_count, model_perf);
`endif
      if (((rd_req & ~exp_grant) != '0) && model_perf != 32'hFFFF_FFFF) model_perf++;
      if (g >= 0) begin
         a = rd_addr[g*AW +: AW];
         d = (wr_req && wr_addr == a) ? wr_data : model_mem[a];
         exp_q.push_back({IW'(g), d});
         model_ptr = (g + 1) % NR;
      end
      if (wr_req) model_mem[wr_addr] = wr_data;
      last_g = g;
      @(negedge clk);
   endtask

   // Walks the whole clear sequence right after reset release.
   task automatic check_clear();
      for (int c = 0; c < SZ; c++) begin
         rd_req  = NR'($urandom_range(0, 15));
         rd_addr = (NR*AW)'({$urandom, $urandom});
         wr_req  = 1'($urandom_range(0, 1));
         wr_addr = rand_addr();
         wr_data = DW'($urandom);
         #1;
         check("clr_resp_valid", 32'(rd_resp_valid), 32'd0);
         check("clr_resp_id", 32'(rd_resp_id), 32'd0);
         check("clr_we", 32'(sram_write_en), 32'd1);
         check("clr_waddr", 32'(sram_write_addr), 32'(c));
         check("clr_wdata", 32'(sram_write_data), 32'd0);
         check("clr_grant", 32'(rd_grant), 32'd0);
         check("clr_ren", 32'(sram_read_en), 32'd0);
         check("clr_wr_ack", 32'(wr_ack), 32'd0);
         check("clr_init_done", 32'(init_done), 32'd0);
         check("clr_state", 32'(dbg_state), 32'(ARB_CLEAR));
`ifdef SRAM_PORT_ARBITER_PERF_EN
         check("clr_perf", perf_stall_count, 32'd0);
`endif
         @(negedge clk);
      end
      for (int i = 0; i < SZ; i++) model_mem[i] = '0;
      rd_req = '0;
      wr_req = 1'b0;
   endtask

   // Reset for one cycle; memory content is scrambled meanwhile.
   task automatic do_reset(input bit expect_inflight);
      reset        = 1'b1;
      rd_req       = '0;
      wr_req       = 1'b0;
      fill_garbage = 1'b1;
      #1;
      if (expect_inflight) check("inflight_valid", 32'(rd_resp_valid), 32'd1);
      @(negedge clk);
      reset        = 1'b0;
      fill_garbage = 1'b0;
      exp_q.delete();
      model_ptr  = 0;
      model_perf = '0;
      check_clear();
   endtask

   task automatic set_addr(input int r, input logic [AW-1:0] a);
      rd_addr[r*AW +: AW] = a;
   endtask

   task automatic random_phase(input int n);
      for (int k = 0; k < n; k++) begin
         for (int r = 0; r < NR; r++) begin
            if (!rd_req[r] && $urandom_range(0, 1) == 1) begin
               rd_req[r] = 1'b1;
               set_addr(r, rand_addr());
            end
         end
         wr_req  = ($urandom_range(0, 2) == 0);
         wr_addr = rand_addr();
         wr_data = DW'($urandom);
         run_cycle();
         if (last_g >= 0) rd_req[last_g] = 1'b0;
      end
      rd_req = '0;
      wr_req = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   logic [31:0] perf_before;
   logic [NR-1:0] exp_seq [3];

   initial begin
      reset     = 1'b1;
      rd_req    = '0;
      rd_addr   = '0;
      wr_req    = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      model_ptr = 0;
      model_perf = '0;
      last_g    = -1;
      @(negedge clk);

      // Reset and full clear sweep; init_done checked on the first RUN cycle.
      do_reset(1'b0);

      // All four requesting for 8 cycles: grants rotate 0,1,2,3,0,1,2,3.
      rd_req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < NR; r++) set_addr(r, rand_addr());
         run_cycle();
         check("rr_all_seq", 32'(dut_grant_seen), 32'(1 << (i % 4)));
      end
      rd_req = '0;
      run_cycle();

      // Same-address read and write: response carries the new data.
      rd_req  = 4'b0100;
      set_addr(2, 6'd5);
      wr_req  = 1'b1;
      wr_addr = 6'd5;
      wr_data = 20'hABCDE;
      run_cycle();
      rd_req = '0;
      wr_req = 1'b0;
      #1;
      check("coll_valid", 32'(rd_resp_valid), 32'd1);
      check("coll_id", 32'(rd_resp_id), 32'd2);
      check("coll_data", 32'(rd_resp_data), 32'hABCDE);
      run_cycle();

      // Move pointer to 2, then 1010 held: grants 3,1,3.
      rd_req = 4'b0010;
      set_addr(1, 6'd5);
      run_cycle();
      exp_seq[0] = 4'b1000;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b1000;
      rd_req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         set_addr(1, rand_addr());
         set_addr(3, rand_addr());
         run_cycle();
         check("rr_wrap_seq", 32'(dut_grant_seen), 32'(exp_seq[i]));
      end
      rd_req = '0;
      run_cycle();

`ifdef SRAM_PORT_ARBITER_PERF_EN
      perf_before = perf_stall_count;
      rd_req = 4'b0111;
      for (int i = 0; i < 3; i++) run_cycle();
      rd_req = '0;
      check("perf_delta", perf_stall_count - perf_before, 32'd3);
      run_cycle();
`else
      perf_before = '0;
`endif

      random_phase(300);

      // Reset one cycle after a grant: in-flight response dropped, clear restarts.
      rd_req = 4'b0001;
      set_addr(0, rand_addr());
      run_cycle();
      do_reset(1'b1);

      random_phase(100);
      run_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 1r1w SRAM wrapper (fakeram_1r1w_* style) between NUM_REQ read requesters and one writer.
- Round-robin read arbitration, single-cycle read latency, response tagged with requester id.
- After every reset, a clear sequencer writes zero to all SIZE entries before any access is accepted.
- Sits between the cache/tag pipelines and the SRAM wrapper instance.

Parameters:
NUM_REQ, 4, number of read requesters (>=2)
DATA_WIDTH, 20, SRAM word width
SIZE, 64, SRAM depth (need not be a power of 2, e.g. 52)
ADDR_WIDTH, $clog2(SIZE), address width
ID_WIDTH, $clog2(NUM_REQ), requester id width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_req  in  NUM_REQ  per-requester read request
rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses; requester i uses slice i
rd_grant  out  NUM_REQ  one-hot grant, same cycle as request
rd_resp_valid  out  1  read data valid
rd_resp_id  out  ID_WIDTH  requester that owns rd_resp_data
rd_resp_data  out  DATA_WIDTH  read data
wr_req  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_ack  out  1  write accepted this cycle
init_done  out  1  clear sequence finished
sram_read_en  out  1  to SRAM read_en
sram_read_addr  out  ADDR_WIDTH  to SRAM read_addr
sram_read_data  in  DATA_WIDTH  from SRAM read_data; valid the cycle after sram_read_en
sram_write_en  out  1  to SRAM write_en
sram_write_addr  out  ADDR_WIDTH  to SRAM write_addr
sram_write_data  out  DATA_WIDTH  to SRAM write_data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: state=CLEAR, clear_ptr=0, rr_ptr=0, init_done=0, rd_resp_valid=0, rd_resp_id=0.
- State machine: two states, CLEAR and RUN.
- CLEAR state:
  - sram_write_en=1, sram_write_addr=clear_ptr, sram_write_data=0.
  - clear_ptr increments each cycle.
  - When clear_ptr==SIZE-1, next state is RUN. Total duration is exactly SIZE cycles.
  - Never reaches addresses >= SIZE, including non-power-of-2 SIZE.
  - rd_grant=0, wr_ack=0, sram_read_en=0.
- init_done: registered; it is 1 exactly in the RUN state, i.e. from cycle SIZE after reset deassertion.
- RUN state, reads:
  - Combinational round-robin grant. Search starts at rr_ptr and picks the first asserted rd_req, wrapping from NUM_REQ-1 to 0.
  - sram_read_en = |rd_grant. sram_read_addr = the granted requester's address.
  - On a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read response:
  - rd_resp_valid <= |rd_grant; rd_resp_id <= g (registered).
  - rd_resp_data = sram_read_data, passed through unregistered. Latency is 1 cycle from grant to valid.
  - Ungranted requesters hold rd_req and rd_addr stable until granted.
- RUN state, writes:
  - wr_ack = wr_req (combinational). sram_write_en/addr/data = wr_req/wr_addr/wr_data.
  - Writes are never stalled.
- Same-address read and write in the same cycle: the SRAM is NEW_DATA, so the response carries wr_data. The arbiter adds no bypass logic.
- Reset mid-operation:
  - Any in-flight response is dropped; rd_resp_valid=0 in the cycle after reset is sampled.
  - The clear sequence restarts from 0.
- Back-to-back grants to the same requester are allowed only when no other requester is asserting.

Optional Feature:
- Macro: SRAM_PORT_ARBITER_PERF_EN
- Defined:
  - Adds output perf_stall_count, 32 bits, reset to 0.
  - Increments by 1 each RUN cycle in which (rd_req & ~rd_grant) != 0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and the counter do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package sram_arb_pkg holds the state enum (ARB_CLEAR, ARB_RUN) and the perf counter width constant.
- Sub-module rr_arbiter(NUM_REQ) provides the one-hot round-robin pick, taking request, rr_ptr and update enable.
- Clear FSM and response registers stay in the top module.

Test Plan:
- Reset deasserted, SIZE=52 -> sram_write_en=1 for exactly 52 cycles with addresses 0..51 and data 0; init_done rises at cycle 52; no rd_grant before that.
- RUN, rd_req=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; rd_resp_id follows one cycle later; rd_resp_data matches the model.
- Write addr 5 = 20'hABCDE with requester 2 reading addr 5 in the same cycle -> next cycle rd_resp_valid=1, id=2, data=20'hABCDE.
- rd_req=4'b1010 with rr_ptr=2 -> grant 3, then 1, then 3; rr_ptr wraps correctly.
- Reset asserted one cycle after a grant -> rd_resp_valid=0 next cycle; clear restarts at address 0; init_done=0.
- With PERF_EN, rd_req=4'b0111 for 3 cycles in RUN -> perf_stall_count=3.
